// File: rtl/switch_pkg.sv
// Shared constants and types for the switch debounce path.
package switch_pkg;

  localparam int unsigned SW_WIDTH          = 2;
  localparam int unsigned SW_STABLE_CYCLES  = 50000;
  localparam int unsigned SW_COUNT_W        = 16;
  localparam int unsigned SIM_STABLE_CYCLES = 4;

  typedef logic [SW_WIDTH-1:0] sw_vec_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous inputs; resets to zero.
module sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      o_q  <= '0;
    end else begin
      r_s1 <= i_d;
      o_q  <= r_s1;
    end
  end

endmodule

// File: rtl/switch_debounce.sv
// Synchronises and debounces a switch vector; emits a one-cycle change strobe.
// Optional SWITCH_DEBOUNCE_EDGE_EN adds registered per-bit RISE/FALL strobes.
module switch_debounce
  import switch_pkg::*;
#(
  parameter int unsigned WIDTH         = SW_WIDTH,
  parameter int unsigned STABLE_CYCLES = SW_STABLE_CYCLES,
  parameter int unsigned COUNT_W       = SW_COUNT_W
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  output logic             CHANGED
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  ,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL
`endif
);

  localparam logic [COUNT_W-1:0] CNT_LAST = COUNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0]   w_s;
  logic [WIDTH-1:0]   r_cand;
  logic [COUNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_o;
  logic               r_changed;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0]   r_rise;
  logic [WIDTH-1:0]   r_fall;
`endif

  sync2 #(.W(WIDTH)) u_sync (
    .clk   (CLK),
    .rst_n (RESETN),
    .i_d   (I),
    .o_q   (w_s)
  );

  // Whole vector shares one counter: any bit moving restarts the count.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_cand    <= '0;
      r_cnt     <= '0;
      r_o       <= '0;
      r_changed <= 1'b0;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
      r_rise    <= '0;
      r_fall    <= '0;
`endif
    end else begin
      r_changed <= 1'b0;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
      r_rise    <= '0;
      r_fall    <= '0;
`endif
      if (w_s != r_cand) begin
        r_cand <= w_s;
        r_cnt  <= '0;
      end else if (r_cand != r_o) begin
        if (r_cnt == CNT_LAST) begin
          r_o       <= r_cand;
          r_changed <= 1'b1;
          r_cnt     <= '0;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
          r_rise    <= r_cand & ~r_o;
          r_fall    <= ~r_cand & r_o;
`endif
        end else begin
          r_cnt <= r_cnt + COUNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign O       = r_o;
  assign CHANGED = r_changed;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  assign RISE    = r_rise;
  assign FALL    = r_fall;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: directed plan plus random holds vs a sliding-window model.
module tb_switch_debounce;
  import switch_pkg::*;

  localparam int unsigned SC = SIM_STABLE_CYCLES;

  logic    CLK;
  logic    RESETN;
  sw_vec_t I;
  sw_vec_t O;
  logic    CHANGED;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  sw_vec_t RISE;
  sw_vec_t FALL;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: hist[j] = I sampled j edges ago (hist[0] = this edge).
  sw_vec_t hist [0:SC+2];
  sw_vec_t exp_o;
  logic    exp_changed;
  sw_vec_t exp_rise;
  sw_vec_t exp_fall;

  switch_debounce #(
    .WIDTH         (SW_WIDTH),
    .STABLE_CYCLES (SC),
    .COUNT_W       (SW_COUNT_W)
  ) dut (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .I       (I),
    .O       (O),
    .CHANGED (CHANGED)
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    ,
    .RISE    (RISE),
    .FALL    (FALL)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j <= SC + 2; j++) hist[j] = '0;
    exp_o       = '0;
    exp_changed = 1'b0;
    exp_rise    = '0;
    exp_fall    = '0;
  endtask

  // O adopts v once the two-edge-delayed input has read v for SC+1 edges in a row.
  task automatic model_edge();
    logic    steady;
    sw_vec_t v;
    for (int j = SC + 2; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = I;
    v = hist[2];
    steady = 1'b1;
    for (int j = 3; j <= SC + 2; j++) if (hist[j] != v) steady = 1'b0;
    exp_changed = 1'b0;
    exp_rise    = '0;
    exp_fall    = '0;
    if (steady && v != exp_o) begin
      exp_rise    = v & ~exp_o;
      exp_fall    = ~v & exp_o;
      exp_o       = v;
      exp_changed = 1'b1;
    end
  endtask

  task automatic step(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    check({tag, "_o"}, 32'(O), 32'(exp_o));
    check({tag, "_chg"}, 32'(CHANGED), 32'(exp_changed));
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    check({tag, "_rise"}, 32'(RISE), 32'(exp_rise));
    check({tag, "_fall"}, 32'(FALL), 32'(exp_fall));
`endif
  endtask

  task automatic hold(input string tag, input sw_vec_t v, input int n);
    I = v;
    for (int k = 0; k < n; k++) step(tag);
  endtask

  initial begin
    sw_vec_t v;
    RESETN = 1'b0;
    I      = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_o", 32'(O), 32'h0);
    check("rst_chg", 32'(CHANGED), 32'h0);
    @(negedge CLK);
    RESETN = 1'b1;

    // Idle at 00.
    hold("idle", 2'b00, 20);
    check("idle_final", 32'(O), 32'h0);

    // Single-bit change: O moves on the 7th edge, strobe for exactly that cycle.
    hold("rise01_wait", 2'b01, 6);
    check("rise01_early", 32'(O), 32'h0);
    step("rise01_edge");
    check("rise01_o", 32'(O), 32'h1);
    check("rise01_chg", 32'(CHANGED), 32'h1);
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    check("rise01_r", 32'(RISE), 32'h1);
    check("rise01_f", 32'(FALL), 32'h0);
`endif
    step("rise01_after");
    check("rise01_chg_off", 32'(CHANGED), 32'h0);
    hold("back00", 2'b00, 10);

    // Short glitch never reaches O.
    hold("glitch", 2'b10, 3);
    hold("glitch_ret", 2'b00, 10);
    check("glitch_o", 32'(O), 32'h0);

    // Bounce 00/11, then settle at 11.
    for (int t = 0; t < 10; t++) hold("bounce", (t % 2 == 0) ? 2'b11 : 2'b00, 2);
    check("bounce_o", 32'(O), 32'h0);
    hold("settle11_wait", 2'b11, 6);
    check("settle11_early", 32'(O), 32'h0);
    step("settle11_edge");
    check("settle11_o", 32'(O), 32'h3);
    check("settle11_chg", 32'(CHANGED), 32'h1);
    hold("settle11_hold", 2'b11, 4);

    // Async reset mid-count while moving toward 00.
    hold("pre_rst", 2'b00, 5);
    RESETN = 1'b0;
    #1;
    model_reset();
    check("midrst_o", 32'(O), 32'h0);
    check("midrst_chg", 32'(CHANGED), 32'h0);
    @(negedge CLK);
    RESETN = 1'b1;
    hold("post_rst", 2'b00, 10);

    // Both bits move: 01 -> 10.
    hold("to01", 2'b01, 10);
    check("to01_o", 32'(O), 32'h1);
    hold("to10_wait", 2'b10, 6);
    step("to10_edge");
    check("to10_o", 32'(O), 32'h2);
    check("to10_chg", 32'(CHANGED), 32'h1);
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    check("to10_r", 32'(RISE), 32'h2);
    check("to10_f", 32'(FALL), 32'h1);
`endif

    // Random holds of 1..8 cycles around the acceptance threshold.
    for (int s = 0; s < 60; s++) begin
      v = sw_vec_t'($urandom_range(0, 3));
      hold("rand", v, int'($urandom_range(1, 8)));
    end
    hold("rand_tail", 2'b01, 12);
    check("rand_tail_o", 32'(O), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
